// File: rtl/video_frame_buf_sched.sv
// Purpose : hands out DDR frame buffers to one capture writer and one frame reader; the reader always gets the newest complete frame.
// Latency : grant/drop/ack pulses and their index/address outputs are registered, 1 cycle after the input pulse.
// Backpress: none; pulse interface. A SOF with no free buffer is dropped (wr_drop_o) and the rest of that frame is ignored.
//
// Ports:
//   ACLK/ARESET            clock, synchronous active-high reset
//   enable_i               scheduler enable; low discards the in-flight frame and invalidates latest
//   base_addr_i            address of buffer 0
//   frame_stride_i         byte distance between buffers
//   wr_sof_i/eof_i/err_i   writer frame events
//   wr_grant_o/wr_drop_o   writer grant or drop pulse
//   wr_idx_o/wr_addr_o     buffer granted to the writer
//   rd_req_i/rd_rel_i      reader request and release of the newest frame
//   rd_ack_o               reader grant pulse
//   rd_idx_o/rd_addr_o     buffer held by the reader
//   latest_valid_o         a completed frame is available
//   frame_cnt_o            completed frames (wraps)
//   drop_cnt_o             dropped or aborted frames (saturates)
module video_frame_buf_sched #(
    parameter int NUM_BUFS = 3,
    parameter int AW       = 32,
    parameter int CW       = 16
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          enable_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW-1:0] frame_stride_i,
    input  logic          wr_sof_i,
    input  logic          wr_eof_i,
    input  logic          wr_err_i,
    output logic          wr_grant_o,
    output logic          wr_drop_o,
    output logic [2:0]    wr_idx_o,
    output logic [AW-1:0] wr_addr_o,
    input  logic          rd_req_i,
    input  logic          rd_rel_i,
    output logic          rd_ack_o,
    output logic [2:0]    rd_idx_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          latest_valid_o,
    output logic [CW-1:0] frame_cnt_o,
    output logic [CW-1:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACTIVE = 2'd1,
        W_DROP   = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_HOLD = 1'b1
    } rstate_t;

    wstate_t       wstate;
    rstate_t       rstate;
    logic [2:0]    latest_idx;

    logic [NUM_BUFS-1:0] free_bufs;
    logic                sel_found;
    logic [2:0]          sel_idx;
    logic                abort;
    logic                do_sel;
    logic                sel_fail;
    logic [1:0]          drop_inc;
    logic [CW:0]         drop_sum;
    logic [CW-1:0]       drop_next;
    logic [AW-1:0]       wr_mul;
    logic [AW-1:0]       rd_mul;

    // Free = not held by the reader and not the latest completed frame.
    // Uses registered state only, so a same-cycle rd_rel_i still counts as held.
    always_comb begin
        free_bufs = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            free_bufs[i] = !((rstate == R_HOLD) && (rd_idx_o == 3'(i))) &&
                           !(latest_valid_o && (latest_idx == 3'(i)));
        end
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (free_bufs[i]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
            end
        end
    end

    // An error outranks a SOF outside W_IDLE; a SOF in W_ACTIVE also aborts the open frame.
    assign abort    = enable_i && (wstate == W_ACTIVE) && (wr_err_i || wr_sof_i);
    assign do_sel   = enable_i && wr_sof_i && !(wr_err_i && (wstate != W_IDLE));
    assign sel_fail = do_sel && !sel_found;
    assign drop_inc = {1'b0, abort} + {1'b0, sel_fail};

    // Saturating drop counter: an abort and a failed reselect can land in the same cycle.
    assign drop_sum  = {1'b0, drop_cnt_o} + {{(CW-1){1'b0}}, drop_inc};
    assign drop_next = drop_sum[CW] ? {CW{1'b1}} : drop_sum[CW-1:0];

    assign wr_mul = AW'(sel_idx) * frame_stride_i;
    assign rd_mul = AW'(latest_idx) * frame_stride_i;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate         <= W_IDLE;
            rstate         <= R_IDLE;
            latest_idx     <= '0;
            latest_valid_o <= 1'b0;
            wr_grant_o     <= 1'b0;
            wr_drop_o      <= 1'b0;
            wr_idx_o       <= '0;
            wr_addr_o      <= '0;
            rd_ack_o       <= 1'b0;
            rd_idx_o       <= '0;
            rd_addr_o      <= '0;
            frame_cnt_o    <= '0;
            drop_cnt_o     <= '0;
        end else begin
            wr_grant_o <= 1'b0;
            wr_drop_o  <= 1'b0;
            rd_ack_o   <= 1'b0;
            drop_cnt_o <= drop_next;

            // Writer
            if (!enable_i) begin
                wstate         <= W_IDLE;
                latest_valid_o <= 1'b0;
            end else if (do_sel) begin
                if (sel_found) begin
                    wstate     <= W_ACTIVE;
                    wr_grant_o <= 1'b1;
                    wr_idx_o   <= sel_idx;
                    wr_addr_o  <= base_addr_i + wr_mul;
                end else begin
                    wstate    <= W_DROP;
                    wr_drop_o <= 1'b1;
                end
            end else begin
                case (wstate)
                    W_ACTIVE: begin
                        if (wr_err_i) begin
                            wstate <= W_IDLE;
                        end else if (wr_eof_i) begin
                            wstate         <= W_IDLE;
                            latest_idx     <= wr_idx_o;
                            latest_valid_o <= 1'b1;
                            frame_cnt_o    <= frame_cnt_o + CW'(1);
                        end
                    end
                    W_DROP: begin
                        if (wr_err_i || wr_eof_i) begin
                            wstate <= W_IDLE;
                        end
                    end
                    W_IDLE:  ;
                    default: wstate <= W_IDLE;
                endcase
            end

            // Reader: sees the latest_idx registered before any same-cycle EOF.
            case (rstate)
                R_IDLE: begin
                    if (rd_req_i && latest_valid_o) begin
                        rstate    <= R_HOLD;
                        rd_ack_o  <= 1'b1;
                        rd_idx_o  <= latest_idx;
                        rd_addr_o <= base_addr_i + rd_mul;
                    end
                end
                R_HOLD: begin
                    // A request beats a same-cycle release: the reader moves to the newest frame.
                    if (rd_req_i && latest_valid_o) begin
                        rd_ack_o  <= 1'b1;
                        rd_idx_o  <= latest_idx;
                        rd_addr_o <= base_addr_i + rd_mul;
                    end else if (rd_rel_i) begin
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_frame_buf_sched.sv
// Bench for video_frame_buf_sched: a 3-buffer instance (a_*) and a 2-buffer, 2-bit-counter instance (b_*).
// Expected grant/drop/ack events are queued as stimulus is driven and compared when the DUT pulses.
module tb_video_frame_buf_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;   // 2'b10 grant/ack, 2'b01 drop
        logic [2:0]  idx;
        logic [31:0] addr;
    } ev_t;

    ev_t wq_a[$];
    ev_t rq_a[$];
    ev_t wq_b[$];
    ev_t rq_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: NUM_BUFS=3
    logic        a_rst, a_en, a_sof, a_eof, a_err, a_req, a_rel;
    logic [31:0] a_base, a_stride;
    logic        a_grant, a_drop, a_ack, a_lv;
    logic [2:0]  a_widx, a_ridx;
    logic [31:0] a_waddr, a_raddr;
    logic [15:0] a_fcnt, a_dcnt;

    // DUT B: NUM_BUFS=2, CW=2
    logic        b_rst, b_en, b_sof, b_eof, b_err, b_req, b_rel;
    logic [31:0] b_base, b_stride;
    logic        b_grant, b_drop, b_ack, b_lv;
    logic [2:0]  b_widx, b_ridx;
    logic [31:0] b_waddr, b_raddr;
    logic [1:0]  b_fcnt, b_dcnt;

    video_frame_buf_sched #(.NUM_BUFS(3), .AW(32), .CW(16)) u_dut_a (
        .ACLK(clk), .ARESET(a_rst), .enable_i(a_en),
        .base_addr_i(a_base), .frame_stride_i(a_stride),
        .wr_sof_i(a_sof), .wr_eof_i(a_eof), .wr_err_i(a_err),
        .wr_grant_o(a_grant), .wr_drop_o(a_drop), .wr_idx_o(a_widx), .wr_addr_o(a_waddr),
        .rd_req_i(a_req), .rd_rel_i(a_rel),
        .rd_ack_o(a_ack), .rd_idx_o(a_ridx), .rd_addr_o(a_raddr),
        .latest_valid_o(a_lv), .frame_cnt_o(a_fcnt), .drop_cnt_o(a_dcnt)
    );

    video_frame_buf_sched #(.NUM_BUFS(2), .AW(32), .CW(2)) u_dut_b (
        .ACLK(clk), .ARESET(b_rst), .enable_i(b_en),
        .base_addr_i(b_base), .frame_stride_i(b_stride),
        .wr_sof_i(b_sof), .wr_eof_i(b_eof), .wr_err_i(b_err),
        .wr_grant_o(b_grant), .wr_drop_o(b_drop), .wr_idx_o(b_widx), .wr_addr_o(b_waddr),
        .rd_req_i(b_req), .rd_rel_i(b_rel),
        .rd_ack_o(b_ack), .rd_idx_o(b_ridx), .rd_addr_o(b_raddr),
        .latest_valid_o(b_lv), .frame_cnt_o(b_fcnt), .drop_cnt_o(b_dcnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input logic [1:0] kind, input logic [2:0] idx,
                                  input logic [31:0] base, input logic [31:0] stride);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.addr = base + 32'(idx) * stride;
        return e;
    endfunction

    function automatic void exp_grant_a(input logic [2:0] idx);
        wq_a.push_back(mk_ev(2'b10, idx, a_base, a_stride));
    endfunction
    function automatic void exp_drop_a();
        wq_a.push_back(mk_ev(2'b01, 3'd0, a_base, a_stride));
    endfunction
    function automatic void exp_ack_a(input logic [2:0] idx);
        rq_a.push_back(mk_ev(2'b10, idx, a_base, a_stride));
    endfunction
    function automatic void exp_grant_b(input logic [2:0] idx);
        wq_b.push_back(mk_ev(2'b10, idx, b_base, b_stride));
    endfunction
    function automatic void exp_drop_b();
        wq_b.push_back(mk_ev(2'b01, 3'd0, b_base, b_stride));
    endfunction
    function automatic void exp_ack_b(input logic [2:0] idx);
        rq_b.push_back(mk_ev(2'b10, idx, b_base, b_stride));
    endfunction

    // One pulse cycle followed by one idle cycle; called #1 after a rising edge.
    task automatic step_a(input logic sof, input logic eof, input logic err,
                          input logic req, input logic rel);
        a_sof = sof; a_eof = eof; a_err = err; a_req = req; a_rel = rel;
        @(posedge clk); #1;
        a_sof = 1'b0; a_eof = 1'b0; a_err = 1'b0; a_req = 1'b0; a_rel = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic sof, input logic eof, input logic err,
                          input logic req, input logic rel);
        b_sof = sof; b_eof = eof; b_err = err; b_req = req; b_rel = rel;
        @(posedge clk); #1;
        b_sof = 1'b0; b_eof = 1'b0; b_err = 1'b0; b_req = 1'b0; b_rel = 1'b0;
        @(posedge clk); #1;
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    always @(negedge clk) begin : mon
        ev_t e;
        if (a_grant || a_drop) begin
            if (wq_a.size() == 0) chk("a_wr_unexpected", {a_grant, a_drop}, 2'b00);
            else begin
                e = wq_a.pop_front();
                chk("a_wr_kind", {a_grant, a_drop}, e.kind);
                if (e.kind == 2'b10) begin
                    chk("a_wr_idx", a_widx, e.idx);
                    chk("a_wr_addr", a_waddr, e.addr);
                end
            end
        end
        if (a_ack) begin
            if (rq_a.size() == 0) chk("a_rd_unexpected", a_ack, 1'b0);
            else begin
                e = rq_a.pop_front();
                chk("a_rd_idx", a_ridx, e.idx);
                chk("a_rd_addr", a_raddr, e.addr);
            end
        end
        if (b_grant || b_drop) begin
            if (wq_b.size() == 0) chk("b_wr_unexpected", {b_grant, b_drop}, 2'b00);
            else begin
                e = wq_b.pop_front();
                chk("b_wr_kind", {b_grant, b_drop}, e.kind);
                if (e.kind == 2'b10) begin
                    chk("b_wr_idx", b_widx, e.idx);
                    chk("b_wr_addr", b_waddr, e.addr);
                end
            end
        end
        if (b_ack) begin
            if (rq_b.size() == 0) chk("b_rd_unexpected", b_ack, 1'b0);
            else begin
                e = rq_b.pop_front();
                chk("b_rd_idx", b_ridx, e.idx);
                chk("b_rd_addr", b_raddr, e.addr);
            end
        end
    end

    task automatic chk_all_zero_a(input string tag);
        chk({tag, "_pulses"}, {a_grant, a_drop, a_ack}, 3'b000);
        chk({tag, "_widx"}, a_widx, 3'd0);
        chk({tag, "_waddr"}, a_waddr, 32'd0);
        chk({tag, "_ridx"}, a_ridx, 3'd0);
        chk({tag, "_raddr"}, a_raddr, 32'd0);
        chk({tag, "_latest_valid"}, a_lv, 1'b0);
        chk({tag, "_frame_cnt"}, a_fcnt, 16'd0);
        chk({tag, "_drop_cnt"}, a_dcnt, 16'd0);
    endtask

    initial begin : drive_a
        a_rst = 1'b1; a_en = 1'b1; a_base = 32'h1000_0000; a_stride = 32'h0004_B000;
        a_sof = 1'b0; a_eof = 1'b0; a_err = 1'b0; a_req = 1'b0; a_rel = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_rst = 1'b0;
        chk_all_zero_a("a_reset");

        // No completed frame yet: request is ignored.
        step_a(0, 0, 0, 1, 0);

        // Three frames: grants 0,1,0, latest ends at 0.
        exp_grant_a(0); step_a(1, 0, 0, 0, 0); step_a(0, 1, 0, 0, 0);
        exp_grant_a(1); step_a(1, 0, 0, 0, 0); step_a(0, 1, 0, 0, 0);
        exp_grant_a(0); step_a(1, 0, 0, 0, 0); step_a(0, 1, 0, 0, 0);
        chk("a_t1_frame_cnt", a_fcnt, 16'd3);
        chk("a_t1_latest_valid", a_lv, 1'b1);

        // Reader holds 0 (latest 0): writer gets lowest free, 1.
        exp_ack_a(0);   step_a(0, 0, 0, 1, 0);
        exp_grant_a(1); step_a(1, 0, 0, 0, 0); step_a(0, 1, 0, 0, 0);
        exp_ack_a(1);   step_a(0, 0, 0, 1, 0);
        // Held 1, latest 1 -> grant 0.
        exp_grant_a(0); step_a(1, 0, 0, 0, 0);

        // Abort: nothing published, drop counted.
        step_a(0, 0, 1, 0, 0);
        chk("a_t4_err_frame_cnt", a_fcnt, 16'd4);
        chk("a_t4_err_drop_cnt", a_dcnt, 16'd1);
        // SOF, SOF without EOF: second SOF counts a drop and regrants.
        exp_grant_a(0); step_a(1, 0, 0, 0, 0);
        exp_grant_a(0); step_a(1, 0, 0, 0, 0);
        chk("a_t4_resof_drop_cnt", a_dcnt, 16'd2);
        step_a(0, 1, 0, 0, 0);   // latest 0, frame 5

        // Held 1, latest 0 -> grant 2; EOF with request gives the old latest 0.
        exp_grant_a(2); step_a(1, 0, 0, 0, 0);
        exp_ack_a(0);   step_a(0, 1, 0, 1, 0);
        chk("a_t5_frame_cnt", a_fcnt, 16'd6);
        // Request plus release: ack with new latest 2, reader stays holding 2.
        exp_ack_a(2);   step_a(0, 0, 0, 1, 1);
        exp_grant_a(0); step_a(1, 0, 0, 0, 0); step_a(0, 1, 0, 0, 0);
        // Held 2, latest 0 -> 1 (would be 1... only if 2 held; idle reader would also skip 0 -> 1, so next)
        exp_grant_a(1); step_a(1, 0, 0, 0, 0); step_a(0, 1, 0, 0, 0);
        // Held 2, latest 1 -> 0; an idle reader would also give 0, so probe with latest 0 instead.
        chk("a_t5_frame_cnt2", a_fcnt, 16'd8);

        // Disable mid-frame: writer idle, latest invalid, drop not counted.
        exp_grant_a(0); step_a(1, 0, 0, 0, 0);
        a_en = 1'b0;
        step_a(0, 0, 0, 0, 0);
        a_en = 1'b1;
        chk("a_t6_dis_latest_valid", a_lv, 1'b0);
        chk("a_t6_dis_drop_cnt", a_dcnt, 16'd2);
        step_a(0, 1, 0, 0, 0);   // writer idle: EOF ignored
        chk("a_t6_dis_frame_cnt", a_fcnt, 16'd8);
        chk("a_t6_dis_latest_valid2", a_lv, 1'b0);
        // Still holding 2, latest invalid -> grant 0; new base applies at this grant.
        a_base = 32'h2000_0000;
        exp_grant_a(0); step_a(1, 0, 0, 0, 0);
        // Reset mid-frame.
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        chk_all_zero_a("a_t6_reset");
        step_a(0, 1, 0, 0, 0);
        chk("a_t6_post_eof_frame_cnt", a_fcnt, 16'd0);
        step_a(0, 0, 0, 1, 0);   // no frame: no ack
    end

    initial begin : drive_b
        b_rst = 1'b1; b_en = 1'b1; b_base = 32'h0000_2000; b_stride = 32'h0000_0100;
        b_sof = 1'b0; b_eof = 1'b0; b_err = 1'b0; b_req = 1'b0; b_rel = 1'b0;
        repeat (3) @(posedge clk);
        #1 b_rst = 1'b0;
        chk("b_reset_drop_cnt", b_dcnt, 2'd0);
        chk("b_reset_frame_cnt", b_fcnt, 2'd0);

        exp_grant_b(0); step_b(1, 0, 0, 0, 0); step_b(0, 1, 0, 0, 0);
        exp_ack_b(0);   step_b(0, 0, 0, 1, 0);
        exp_grant_b(1); step_b(1, 0, 0, 0, 0); step_b(0, 1, 0, 0, 0);
        // Reader holds 0, latest 1: no buffer.
        exp_drop_b();   step_b(1, 0, 0, 0, 0);
        chk("b_t3_drop_cnt", b_dcnt, 2'd1);
        // Release in the same cycle as SOF: released buffer still counts as held.
        exp_drop_b();   step_b(1, 0, 0, 0, 1);
        chk("b_t3_drop_cnt2", b_dcnt, 2'd2);
        exp_grant_b(0); step_b(1, 0, 0, 0, 0); step_b(0, 1, 0, 0, 0);
        exp_grant_b(1); step_b(1, 0, 0, 0, 0); step_b(0, 1, 0, 0, 0);
        chk("b_frame_cnt_wrap", b_fcnt, 2'd0);
        // Hold 1, then make 0 latest: drops saturate at 3.
        exp_ack_b(1);   step_b(0, 0, 0, 1, 0);
        exp_grant_b(0); step_b(1, 0, 0, 0, 0); step_b(0, 1, 0, 0, 0);
        exp_drop_b();   step_b(1, 0, 0, 0, 0);
        chk("b_drop_cnt3", b_dcnt, 2'd3);
        exp_drop_b();   step_b(1, 0, 0, 0, 0);
        chk("b_drop_cnt_sat", b_dcnt, 2'd3);
    end

    initial begin : finish_blk
        repeat (200) @(posedge clk);
        #1;
        chk("a_wr_pending", wq_a.size(), 0);
        chk("a_rd_pending", rq_a.size(), 0);
        chk("b_wr_pending", wq_b.size(), 0);
        chk("b_rd_pending", rq_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
